ahb_decode_mux: RTL and testbench
=================================

AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 Parameter NSLV, default 8: number of AHB-Lite slave ports, 1..16.
REQ-002 Parameter PA_BITS, default 34: physical address width.
REQ-003 Parameter AHBW, default 64: data width.
REQ-004 Parameter TIMEOUT, default 255: wait-state limit in cycles; 0 disables the timeout.
REQ-005 Parameter MAP, default from the package: per-slave BASE and MASK address array.
REQ-006 Port HCLK  input  1: bus clock; the only clock.
REQ-007 Port HRESETn  input  1: reset, asynchronous, active-low.
REQ-008 Port HADDR  input  PA_BITS: address-phase address.
REQ-009 Port HTRANS  input  2: transfer type.
REQ-010 Port HSEL  output  NSLV: one-hot address-phase slave select.
REQ-011 Port HRDATAS  input  NSLV x AHBW: per-slave read data.
REQ-012 Port HREADYOUTS  input  NSLV: per-slave ready.
REQ-013 Port HRESPS  input  NSLV: per-slave response.
REQ-014 Port HRDATA  output  AHBW: muxed read data to the manager.
REQ-015 Port HREADY  output  1: muxed ready, also fed back to all slaves.
REQ-016 Port HRESP  output  1: muxed response.
REQ-017 Port ClearQuar  input  NSLV: per-slave quarantine clear strobe.
REQ-018 Port Quarantined  output  NSLV: sticky per-slave timeout flags.
REQ-019 Port TimeoutErr  output  1: one-cycle pulse when a timeout abort starts.

Function
REQ-020 Slave i SHALL match when (HADDR & MASK[i]) == BASE[i]; on overlap the lowest matching index SHALL win.
REQ-021 HSEL[i] SHALL be set only for a match with Quarantined[i]=0; a quarantined or unmatched address SHALL select the internal default slave.
REQ-022 On HREADY=1, the block SHALL register the data-phase select (slave index or default) and DataActive=HTRANS[1]; it SHALL hold both while HREADY=0.
REQ-023 In state FWD with a real slave selected, HRDATA, HREADY and HRESP SHALL come from that slave; in all other cases HRDATA SHALL be 0.
REQ-024 For a default-slave data phase with DataActive=0, the response SHALL be HREADY=1, HRESP=0 with zero wait states.
REQ-025 For a default-slave data phase with DataActive=1, the FSM SHALL go FWD->ERR1 (HREADY=0, HRESP=1) -> ERR2 (HREADY=1, HRESP=1) -> FWD.
REQ-026 WaitCnt SHALL increment each cycle in FWD with a real slave selected, DataActive=1 and HREADYOUTS[sel]=0; it SHALL clear whenever HREADY=1.
REQ-027 When TIMEOUT!=0 and WaitCnt==TIMEOUT-1 with the slave still stalled, the block SHALL enter ERR1, pulse TimeoutErr, set Quarantined[sel], and ignore that slave's outputs during ERR1/ERR2.
REQ-028 WaitCnt SHALL be $clog2(TIMEOUT+1) bits wide, SHALL saturate and SHALL never wrap.
REQ-029 ClearQuar[i] SHALL clear Quarantined[i] on the next edge; a simultaneous set of the same bit SHALL take priority over the clear.
REQ-030 The address phase accepted with ERR2's HREADY=1 SHALL be decoded normally, with no extra bubble.

Reset
REQ-031 While HRESETn=0: state=FWD, data-phase select=default slave, DataActive=0, WaitCnt=0, Quarantined=0, TimeoutErr=0, giving HREADY=1, HRESP=0, HRDATA=0.
REQ-032 Reset asserted mid-ERR1 or mid-wait SHALL abandon the transfer; the first cycle after deassertion SHALL behave as idle.

Structure
REQ-033 The ahb_map_t BASE/MASK struct, the default map constant, and the FSM state enum (FWD, ERR1, ERR2) SHALL live in the cvw package.
REQ-034 A single sub-module, ahb_default_slave, SHALL implement the ERR1/ERR2 sequencing; decode, mux, WaitCnt and quarantine logic SHALL remain in ahb_decode_mux.

Verification
REQ-035 NONSEQ to slave 2 with HREADYOUTS[2] low for 3 cycles -> HREADY low for 3 cycles, then HRDATA=HRDATAS[2], HRESP=0.
REQ-036 NONSEQ to an unmapped address -> ERR1 then ERR2 (HREADY 0 then 1, HRESP 1 both cycles); an IDLE to the same address -> zero-wait OKAY.
REQ-037 TIMEOUT=4, slave 1 stalls forever -> TimeoutErr pulses on the 4th wait cycle, two-cycle ERROR follows, Quarantined[1]=1, and the next access to slave 1 gets ERROR.
REQ-038 ClearQuar[1] pulse -> Quarantined[1]=0 and the next access to slave 1 is forwarded; a clear coincident with a new timeout on slave 1 -> bit stays 1.
REQ-039 Back-to-back NONSEQ to slaves 0, 3, 0 -> each data phase muxes the correct slave, with no extra wait states.
REQ-040 HRESETn low during a slave stall -> outputs reach reset values immediately; after release, an IDLE gives HREADY=1.

Source files
------------

// File: rtl/cvw.sv
// Shared types for the AHB-Lite decode/response mux.
//   ahb_map_t     : one slave's address window; an address matches when
//                   (addr & mask) == base.
//   ahb_map_arr_t : window table for up to MAX_SLV slaves, index 0 first.
//   DEFAULT_MAP   : slave i owns the 4 KiB window at i * 0x1000.
//   statetype     : response FSM states (FWD, ERR1, ERR2).
package cvw;

   localparam int MAX_SLV = 16;

   typedef struct packed {
      logic [63:0] base;
      logic [63:0] mask;
   } ahb_map_t;

   typedef ahb_map_t [MAX_SLV-1:0] ahb_map_arr_t;

   typedef enum logic [1:0] {
      FWD  = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } statetype;

   function automatic ahb_map_arr_t mk_default_map();
      ahb_map_arr_t m;
      for (int i = 0; i < MAX_SLV; i++) begin
         m[i].base = 64'(i) << 12;
         m[i].mask = ~64'hFFF;
      end
      return m;
   endfunction

   localparam ahb_map_arr_t DEFAULT_MAP = mk_default_map();

endpackage

// File: rtl/ahb_decode_mux_default_slave.sv
// Internal default slave: sequences the two-cycle AHB ERROR response.
// Ports:
//   HCLK, HRESETn : bus clock, async active-low reset
//   start_err     : an erroring transfer starts its data phase next cycle
//   state         : current FSM state (observable for debug)
//   hready, hresp : response driven while the default slave owns the bus
// Handshake: start_err is sampled on the rising edge; the following cycle
// is ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1).
module ahb_default_slave
   import cvw::*;
(
   input  logic     HCLK,
   input  logic     HRESETn,
   input  logic     start_err,
   output statetype state,
   output logic     hready,
   output logic     hresp
);

   statetype state_next;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= FWD;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      hready     = 1'b1;
      hresp      = 1'b0;
      case (state)
         FWD:  if (start_err) state_next = ERR1;
         ERR1: begin
            hready     = 1'b0;
            hresp      = 1'b1;
            state_next = ERR2;
         end
         ERR2: begin
            hresp      = 1'b1;
            // ERR2's HREADY=1 accepts the next address phase; a new error
            // must go straight back to ERR1 with no bubble.
            state_next = start_err ? ERR1 : FWD;
         end
         default: state_next = FWD;
      endcase
   end

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and response mux with wait-state timeout.
// Ports:
//   HCLK, HRESETn          : bus clock, async active-low reset
//   HADDR, HTRANS          : manager address phase
//   HSEL                   : one-hot slave select (address phase)
//   HRDATAS, HREADYOUTS,
//   HRESPS                 : per-slave data-phase responses
//   HRDATA, HREADY, HRESP  : muxed response to the manager (HREADY also
//                            feeds back to every slave)
//   ClearQuar              : per-slave strobe clearing a quarantine flag
//   Quarantined            : sticky per-slave timeout flags
//   TimeoutErr             : single-cycle pulse in the cycle a timeout fires
// Handshake: an address phase is accepted on any rising edge with
// HREADY=1; its data phase then lasts until the next HREADY=1 edge.
module ahb_decode_mux
   import cvw::*;
#(
   parameter int           NSLV    = 8,
   parameter int           PA_BITS = 34,
   parameter int           AHBW    = 64,
   parameter int           TIMEOUT = 255,
   parameter ahb_map_arr_t MAP     = DEFAULT_MAP
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [PA_BITS-1:0]        HADDR,
   input  logic [1:0]                HTRANS,
   output logic [NSLV-1:0]           HSEL,
   input  logic [NSLV-1:0][AHBW-1:0] HRDATAS,
   input  logic [NSLV-1:0]           HREADYOUTS,
   input  logic [NSLV-1:0]           HRESPS,
   output logic [AHBW-1:0]           HRDATA,
   output logic                      HREADY,
   output logic                      HRESP,
   input  logic [NSLV-1:0]           ClearQuar,
   output logic [NSLV-1:0]           Quarantined,
   output logic                      TimeoutErr
);

   localparam int IW  = 4;
   // At least one bit even when the timeout is disabled.
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   // Only HTRANS[1] (NONSEQ/SEQ vs IDLE/BUSY) matters here.
   logic unused_htrans0;
   assign unused_htrans0 = HTRANS[0];

   // ---------------- address decode ----------------
   logic          match_found;
   logic [IW-1:0] match_idx;
   logic          match_quar;
   logic          addr_hit;

   always_comb begin
      match_found = 1'b0;
      match_idx   = '0;
      // Scan downward so the lowest matching index is the last one written.
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((HADDR & MAP[i].mask[PA_BITS-1:0]) == MAP[i].base[PA_BITS-1:0]) begin
            match_found = 1'b1;
            match_idx   = IW'(i);
         end
      end
      match_quar = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (match_idx == IW'(i)) match_quar = Quarantined[i];
      end
   end

   assign addr_hit = match_found && !match_quar;

   always_comb begin
      HSEL = '0;
      for (int i = 0; i < NSLV; i++) begin
         HSEL[i] = addr_hit && (match_idx == IW'(i));
      end
   end

   // ---------------- data-phase tracking ----------------
   logic           sel_dflt;     // data phase owned by the default slave
   logic [IW-1:0]  sel_idx;
   logic           data_active;
   logic [WCW-1:0] wait_cnt;

   logic [AHBW-1:0] s_rdata;
   logic            s_ready;
   logic            s_resp;

   always_comb begin
      s_rdata = '0;
      s_ready = 1'b1;
      s_resp  = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel_idx == IW'(i)) begin
            s_rdata = HRDATAS[i];
            s_ready = HREADYOUTS[i];
            s_resp  = HRESPS[i];
         end
      end
   end

   statetype state;
   logic     dflt_ready;
   logic     dflt_resp;
   logic     fwd_slave;
   logic     stall;
   logic     timeout_hit;
   logic     start_err;

   assign fwd_slave   = (state == FWD) && !sel_dflt;
   assign stall       = fwd_slave && data_active && !s_ready;
   assign timeout_hit = (TIMEOUT != 0) && stall && (wait_cnt == WCW'(TIMEOUT - 1));

   // In ERR1/ERR2 the timed-out slave is ignored: the default slave drives.
   assign HREADY     = fwd_slave ? s_ready : dflt_ready;
   assign HRESP      = fwd_slave ? s_resp  : dflt_resp;
   assign HRDATA     = fwd_slave ? s_rdata : '0;
   assign TimeoutErr = timeout_hit;

   // Active transfer to an unmatched or quarantined address, or a timeout.
   assign start_err = (HREADY && HTRANS[1] && !addr_hit) || timeout_hit;

   ahb_default_slave u_dflt (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .start_err (start_err),
      .state     (state),
      .hready    (dflt_ready),
      .hresp     (dflt_resp)
   );

   logic [NSLV-1:0] quar_set;

   always_comb begin
      quar_set = '0;
      for (int i = 0; i < NSLV; i++) begin
         quar_set[i] = timeout_hit && (sel_idx == IW'(i));
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_dflt    <= 1'b1;
         sel_idx     <= '0;
         data_active <= 1'b0;
         wait_cnt    <= '0;
         Quarantined <= '0;
      end else begin
         if (HREADY) begin
            sel_dflt    <= !addr_hit;
            sel_idx     <= match_idx;
            data_active <= HTRANS[1];
            wait_cnt    <= '0;
         end else if (stall && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + WCW'(1);
         end
         // A set in the same cycle as a clear wins.
         Quarantined <= (Quarantined & ~ClearQuar) | quar_set;
      end
   end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Self-checking bench for ahb_decode_mux (NSLV=8, TIMEOUT=4).
// Map: slave i at 0x1000*i (4 KiB) except slave 6, which is widened to
// 0x2000-0x3FFF so it overlaps slaves 2 and 3 and always loses; the
// 0x6000 window and everything at or above 0x8000 are unmapped.
module tb_ahb_decode_mux;
   import cvw::*;

   function automatic ahb_map_arr_t tb_map();
      ahb_map_arr_t m;
      for (int i = 0; i < MAX_SLV; i++) begin
         m[i].base = 64'(i) << 12;
         m[i].mask = ~64'hFFF;
      end
      m[6].base = 64'h2000;
      m[6].mask = ~64'h1FFF;
      return m;
   endfunction

   localparam ahb_map_arr_t TB_MAP = tb_map();

   logic              HCLK;
   logic              HRESETn;
   logic [33:0]       HADDR;
   logic [1:0]        HTRANS;
   logic [7:0]        HSEL;
   logic [7:0][63:0]  HRDATAS;
   logic [7:0]        HREADYOUTS;
   logic [7:0]        HRESPS;
   logic [63:0]       HRDATA;
   logic              HREADY;
   logic              HRESP;
   logic [7:0]        ClearQuar;
   logic [7:0]        Quarantined;
   logic              TimeoutErr;

   int         checks;
   int         errors;
   logic [7:0] exp_quar;

   ahb_decode_mux #(
      .NSLV(8), .PA_BITS(34), .AHBW(64), .TIMEOUT(4), .MAP(TB_MAP)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HSEL        (HSEL),
      .HRDATAS     (HRDATAS),
      .HREADYOUTS  (HREADYOUTS),
      .HRESPS      (HRESPS),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ClearQuar   (ClearQuar),
      .Quarantined (Quarantined),
      .TimeoutErr  (TimeoutErr)
   );

   // ---------------- clock ----------------
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // ---------------- reference model ----------------
   // Slave owning an address, from the map's window layout; -1 = none.
   function automatic int ref_slave(input logic [33:0] a);
      if (a < 34'h8000 && a[15:12] != 4'd6) return int'(a[15:12]);
      return -1;
   endfunction

   function automatic logic [7:0] ref_hsel(input logic [33:0] a);
      int s;
      s = ref_slave(a);
      if (s < 0) return 8'h00;
      if (exp_quar[s]) return 8'h00;
      return 8'h01 << s;
   endfunction

   function automatic logic [33:0] slv_addr(input int s);
      return 34'(s * 4096) + 34'($urandom_range(0, 4095));
   endfunction

   function automatic logic [33:0] unmapped_addr();
      if ($urandom_range(0, 1) == 0) return 34'h6000 + 34'($urandom_range(0, 4095));
      return 34'h10000 + 34'($urandom_range(0, 32'hFFFFF));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(negedge HCLK);
      for (int i = 0; i < 8; i++) HRDATAS[i] = {$urandom(), $urandom()};
   endtask

   task automatic drive_idle();
      HADDR  = unmapped_addr();
      HTRANS = 2'b00;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      HRESETn    = 1'b0;
      HADDR      = 34'h10000;
      HTRANS     = 2'b00;
      HREADYOUTS = 8'hFF;
      HRESPS     = 8'h00;
      ClearQuar  = 8'h00;
      exp_quar   = 8'h00;
      repeat (2) cyc();
      #1;
      checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready: got %0b want 1", HREADY); end
      checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %0b want 0", HRESP); end
      checks++; if (HRDATA !== 64'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
      checks++; if (Quarantined !== 8'h00) begin errors++; $display("FAIL reset_quar: got %h want 00", Quarantined); end
      checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeouterr: got %0b want 0", TimeoutErr); end
      cyc();
      HRESETn = 1'b1;
      cyc();
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0) begin
         errors++; $display("FAIL post_reset_idle: got rdy=%0b resp=%0b data=%h want 1 0 0", HREADY, HRESP, HRDATA);
      end
   endtask

   task automatic test_decode();
      logic [33:0] a;
      logic [7:0]  exp_sel;
      logic [63:0] exp_data;
      int          prev;
      prev = -1;
      for (int n = 0; n < 24; n++) begin
         cyc();
         case ($urandom_range(0, 3))
            0, 1: a = slv_addr($urandom_range(0, 7));
            2:    a = 34'h2000 + 34'($urandom_range(0, 16'h1FFF));
            default: a = unmapped_addr();
         endcase
         HADDR  = a;
         HTRANS = 2'b00;
         #1;
         exp_sel  = ref_hsel(a);
         exp_data = (prev >= 0) ? HRDATAS[prev] : 64'h0;
         checks++; if (HSEL !== exp_sel) begin errors++; $display("FAIL decode_hsel addr=%h: got %b want %b", a, HSEL, exp_sel); end
         checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL decode_idle_resp: got rdy=%0b resp=%0b want 1 0", HREADY, HRESP); end
         checks++; if (HRDATA !== exp_data) begin errors++; $display("FAIL decode_hrdata: got %h want %h", HRDATA, exp_data); end
         prev = ref_slave(a);
      end
      cyc();
      drive_idle();
   endtask

   task automatic test_wait_states();
      cyc();
      HREADYOUTS = 8'hFF;
      HADDR      = slv_addr(2);
      HTRANS     = 2'b10;
      #1;
      checks++; if (HSEL !== 8'h04) begin errors++; $display("FAIL wait_hsel: got %b want 00000100", HSEL); end
      for (int w = 0; w < 3; w++) begin
         cyc();
         drive_idle();
         HREADYOUTS[2] = 1'b0;
         #1;
         checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL wait_stall%0d: got hready=%0b want 0", w, HREADY); end
         checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL wait_no_timeout%0d: got %0b want 0", w, TimeoutErr); end
      end
      cyc();
      HREADYOUTS[2] = 1'b1;
      HRESPS[2]     = 1'b0;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL wait_done_resp: got rdy=%0b resp=%0b want 1 0", HREADY, HRESP); end
      checks++; if (HRDATA !== HRDATAS[2]) begin errors++; $display("FAIL wait_done_data: got %h want %h", HRDATA, HRDATAS[2]); end
   endtask

   task automatic test_default_slave();
      logic [33:0] a;
      a = unmapped_addr();
      cyc();
      HADDR  = a;
      HTRANS = 2'b10;
      #1;
      checks++; if (HSEL !== 8'h00) begin errors++; $display("FAIL dflt_hsel: got %b want 0", HSEL); end
      cyc();
      HTRANS = 2'b00;
      #1;
      checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 64'h0) begin
         errors++; $display("FAIL dflt_err1: got rdy=%0b resp=%0b data=%h want 0 1 0", HREADY, HRESP, HRDATA);
      end
      cyc();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL dflt_err2: got rdy=%0b resp=%0b want 1 1", HREADY, HRESP); end
      cyc();
      HADDR  = unmapped_addr();
      HTRANS = 2'b10;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL dflt_idle_okay: got rdy=%0b resp=%0b want 1 0", HREADY, HRESP); end
      cyc();
      HTRANS = 2'b00;
      #1;
      checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL dflt_err1b: got rdy=%0b resp=%0b want 0 1", HREADY, HRESP); end
      cyc();
      HADDR  = slv_addr(5);
      HTRANS = 2'b10;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL dflt_err2b: got rdy=%0b resp=%0b want 1 1", HREADY, HRESP); end
      checks++; if (HSEL !== 8'h20) begin errors++; $display("FAIL dflt_err2_decode: got %b want 00100000", HSEL); end
      cyc();
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== HRDATAS[5]) begin
         errors++; $display("FAIL dflt_after_err: got rdy=%0b resp=%0b data=%h want 1 0 %h", HREADY, HRESP, HRDATA, HRDATAS[5]);
      end
   endtask

   task automatic test_back_to_back();
      int          seq [3];
      int          prev;
      logic [7:0]  exp_sel;
      logic [63:0] exp_data;
      seq[0] = 0; seq[1] = 3; seq[2] = 0;
      prev = -1;
      HREADYOUTS = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (k < 3) begin
            HADDR  = slv_addr(seq[k]);
            HTRANS = 2'b10;
         end else begin
            drive_idle();
         end
         #1;
         exp_sel  = ref_hsel(HADDR);
         exp_data = (prev >= 0) ? HRDATAS[prev] : 64'h0;
         checks++; if (HSEL !== exp_sel) begin errors++; $display("FAIL b2b_hsel%0d: got %b want %b", k, HSEL, exp_sel); end
         checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL b2b_hready%0d: got %0b want 1", k, HREADY); end
         checks++; if (HRDATA !== exp_data) begin errors++; $display("FAIL b2b_hrdata%0d: got %h want %h", k, HRDATA, exp_data); end
         prev = (k < 3) ? seq[k] : -1;
      end
   endtask

   task automatic test_random();
      int          pend;
      int          stall;
      int          s;
      logic [33:0] a;
      logic        exp_rdy;
      logic        exp_resp;
      logic [63:0] exp_data;
      logic [7:0]  exp_sel;
      pend  = -1;
      stall = 0;
      for (int n = 0; n < 60; n++) begin
         cyc();
         HREADYOUTS = 8'($urandom());
         HRESPS     = 8'($urandom());
         if (pend >= 0 && stall >= 2) HREADYOUTS[pend] = 1'b1;
         if ($urandom_range(0, 4) == 0) begin
            a      = unmapped_addr();
            HTRANS = 2'b00;
         end else begin
            s = $urandom_range(0, 6);
            if (s == 6) s = 7;
            a      = slv_addr(s);
            HTRANS = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
         end
         HADDR = a;
         #1;
         exp_rdy  = (pend >= 0) ? HREADYOUTS[pend] : 1'b1;
         exp_resp = (pend >= 0) ? HRESPS[pend] : 1'b0;
         exp_data = (pend >= 0) ? HRDATAS[pend] : 64'h0;
         exp_sel  = ref_hsel(a);
         checks++; if (HREADY !== exp_rdy) begin errors++; $display("FAIL rand_hready%0d: got %0b want %0b", n, HREADY, exp_rdy); end
         checks++; if (HRESP !== exp_resp) begin errors++; $display("FAIL rand_hresp%0d: got %0b want %0b", n, HRESP, exp_resp); end
         checks++; if (HRDATA !== exp_data) begin errors++; $display("FAIL rand_hrdata%0d: got %h want %h", n, HRDATA, exp_data); end
         checks++; if (HSEL !== exp_sel) begin errors++; $display("FAIL rand_hsel%0d: got %b want %b", n, HSEL, exp_sel); end
         checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL rand_timeouterr%0d: got %0b want 0", n, TimeoutErr); end
         if (exp_rdy) begin
            pend  = ref_slave(a);
            stall = 0;
         end else begin
            stall++;
         end
      end
      cyc();
      HREADYOUTS = 8'hFF;
      HRESPS     = 8'h00;
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rand_drain: got hready=%0b want 1", HREADY); end
   endtask

   task automatic test_timeout();
      cyc();
      HREADYOUTS    = 8'hFF;
      HREADYOUTS[1] = 1'b0;
      HADDR         = slv_addr(1);
      HTRANS        = 2'b10;
      #1;
      checks++; if (HSEL !== 8'h02) begin errors++; $display("FAIL to_hsel: got %b want 00000010", HSEL); end
      for (int w = 1; w <= 4; w++) begin
         cyc();
         drive_idle();
         #1;
         checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got hready=%0b want 0", w, HREADY); end
         checks++; if (TimeoutErr !== (w == 4)) begin errors++; $display("FAIL to_pulse%0d: got %0b want %0b", w, TimeoutErr, (w == 4)); end
      end
      exp_quar[1] = 1'b1;
      cyc();
      HREADYOUTS[1] = 1'b1;  // a late ready from the slave must be ignored
      #1;
      checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1 || HRDATA !== 64'h0) begin
         errors++; $display("FAIL to_err1: got rdy=%0b resp=%0b data=%h want 0 1 0", HREADY, HRESP, HRDATA);
      end
      checks++; if (Quarantined !== exp_quar) begin errors++; $display("FAIL to_quar: got %b want %b", Quarantined, exp_quar); end
      checks++; if (TimeoutErr !== 1'b0) begin errors++; $display("FAIL to_pulse_end: got %0b want 0", TimeoutErr); end
      cyc();
      HADDR  = slv_addr(1);
      HTRANS = 2'b10;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL to_err2: got rdy=%0b resp=%0b want 1 1", HREADY, HRESP); end
      checks++; if (HSEL !== 8'h00) begin errors++; $display("FAIL to_quar_hsel: got %b want 0", HSEL); end
      cyc();
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL to_quar_err1: got rdy=%0b resp=%0b want 0 1", HREADY, HRESP); end
      cyc();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL to_quar_err2: got rdy=%0b resp=%0b want 1 1", HREADY, HRESP); end
   endtask

   task automatic test_reset_mid();
      cyc();
      HREADYOUTS    = 8'hFF;
      HREADYOUTS[2] = 1'b0;
      HADDR         = slv_addr(2);
      HTRANS        = 2'b10;
      cyc();
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got hready=%0b want 0", HREADY); end
      cyc();
      #1;
      HRESETn  = 1'b0;
      exp_quar = 8'h00;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0 || TimeoutErr !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs: got rdy=%0b resp=%0b data=%h to=%0b want 1 0 0 0", HREADY, HRESP, HRDATA, TimeoutErr);
      end
      checks++; if (Quarantined !== exp_quar) begin errors++; $display("FAIL rst_mid_quar: got %b want %b", Quarantined, exp_quar); end
      cyc();
      HRESETn = 1'b1;
      cyc();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 64'h0) begin
         errors++; $display("FAIL rst_mid_idle: got rdy=%0b resp=%0b data=%h want 1 0 0", HREADY, HRESP, HRDATA);
      end
      // reset while the default slave is in ERR1
      HADDR  = unmapped_addr();
      HTRANS = 2'b10;
      cyc();
      drive_idle();
      #1;
      checks++; if (HRESP !== 1'b1 || HREADY !== 1'b0) begin errors++; $display("FAIL rst_err1_pre: got rdy=%0b resp=%0b want 0 1", HREADY, HRESP); end
      HRESETn = 1'b0;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL rst_err1_outputs: got rdy=%0b resp=%0b want 1 0", HREADY, HRESP); end
      cyc();
      HRESETn = 1'b1;
      cyc();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL rst_err1_idle: got rdy=%0b resp=%0b want 1 0", HREADY, HRESP); end
   endtask

   task automatic test_clear_quar();
      cyc();
      HREADYOUTS    = 8'hFF;
      HREADYOUTS[1] = 1'b0;
      HADDR         = slv_addr(1);
      HTRANS        = 2'b10;
      #1;
      checks++; if (HSEL !== 8'h02) begin errors++; $display("FAIL cq_hsel_pre: got %b want 00000010", HSEL); end
      for (int w = 1; w <= 4; w++) begin
         cyc();
         drive_idle();
         ClearQuar = (w == 4) ? 8'h02 : 8'h00;
         #1;
         checks++; if (TimeoutErr !== (w == 4)) begin errors++; $display("FAIL cq_pulse%0d: got %0b want %0b", w, TimeoutErr, (w == 4)); end
      end
      exp_quar[1] = 1'b1;
      cyc();
      ClearQuar     = 8'h00;
      HREADYOUTS[1] = 1'b1;
      #1;
      checks++; if (Quarantined !== exp_quar) begin errors++; $display("FAIL cq_set_wins: got %b want %b", Quarantined, exp_quar); end
      cyc();
      ClearQuar = 8'h02;
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL cq_err2: got rdy=%0b resp=%0b want 1 1", HREADY, HRESP); end
      exp_quar[1] = 1'b0;
      cyc();
      ClearQuar = 8'h00;
      HADDR     = slv_addr(1);
      HTRANS    = 2'b10;
      #1;
      checks++; if (Quarantined !== exp_quar) begin errors++; $display("FAIL cq_cleared: got %b want %b", Quarantined, exp_quar); end
      checks++; if (HSEL !== 8'h02) begin errors++; $display("FAIL cq_hsel_post: got %b want 00000010", HSEL); end
      cyc();
      drive_idle();
      #1;
      checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== HRDATAS[1]) begin
         errors++; $display("FAIL cq_forwarded: got rdy=%0b resp=%0b data=%h want 1 0 %h", HREADY, HRESP, HRDATA, HRDATAS[1]);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 8; i++) HRDATAS[i] = 64'h0;
      test_reset();
      test_decode();
      test_wait_states();
      test_default_slave();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      test_clear_quar();
      repeat (2) cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
